// File: rtl/spi_slave_sync.sv
// Parametrised SPI slave, fully clocked on clk: ss/sck/mosi are oversampled
// through synchronisers and sck edges are detected in the clk domain.
module spi_slave_sync #(
  parameter int   DW          = 16,
  parameter logic CPOL        = 1'b1,
  parameter logic CPHA        = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          ss,
  input  logic          sck,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic          mlb,
  input  logic          ten,
  input  logic [DW-1:0] tdata,
  output logic          tx_ack,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          rx_err,
  output logic          ovf
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [SYNC_STAGES-1:0] ss_sync_r, sck_sync_r, mosi_sync_r;
  logic ss_d_r, sck_d_r, armed_r;
  logic ss_s, sck_s, mosi_s;
  logic ss_fall_s, ss_rise_s, lead_s, trail_s, sample_s, shift_s;

  logic [1:0]    state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [DW-1:0] rx_shift_r, rx_nxt;
  logic [DW-1:0] tx_shift_r, tx_nxt, tx_load_s;
  logic [DW-1:0] rdata_r, rdata_nxt;
  logic          mlb_r, mlb_nxt;
  logic          miso_r, miso_nxt, miso_oe_r;
  logic          done_r, done_nxt, rx_err_r, err_nxt, tx_ack_r, ack_nxt;
  logic          ovf_r, ovf_nxt;

  function automatic logic tx_head(input logic [DW-1:0] v, input logic msb);
    return msb ? v[DW-1] : v[0];
  endfunction

  function automatic logic [DW-1:0] tx_advance(input logic [DW-1:0] v, input logic msb);
    return msb ? {v[DW-2:0], 1'b0} : {1'b0, v[DW-1:1]};
  endfunction

  function automatic logic [DW-1:0] rx_insert(input logic [DW-1:0] v, input logic b,
                                              input logic msb);
    return msb ? {v[DW-2:0], b} : {b, v[DW-1:1]};
  endfunction

  assign ss_s   = ss_sync_r[SYNC_STAGES-1];
  assign sck_s  = sck_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  assign ss_fall_s = ss_d_r & ~ss_s;
  assign ss_rise_s = ~ss_d_r & ss_s;
  assign lead_s    = (sck_d_r == CPOL) && (sck_s != CPOL);
  assign trail_s   = (sck_d_r != CPOL) && (sck_s == CPOL);
  assign sample_s  = CPHA ? trail_s : lead_s;
  assign shift_s   = CPHA ? lead_s : trail_s;

  // Synchronisers plus one-clk history for edge detection. ss resets low and
  // armed_r only sets once ss is seen high, so a frame cut by reset is not resumed.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ss_sync_r   <= {SYNC_STAGES{1'b0}};
      sck_sync_r  <= {SYNC_STAGES{CPOL}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_d_r      <= 1'b0;
      sck_d_r     <= CPOL;
      armed_r     <= 1'b0;
    end else begin
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      ss_d_r      <= ss_s;
      sck_d_r     <= sck_s;
      armed_r     <= armed_r | ss_s;
    end
  end

  // Frame FSM: next-state and datapath decisions.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    rx_nxt    = rx_shift_r;
    tx_nxt    = tx_shift_r;
    tx_load_s = {DW{1'b0}};
    rdata_nxt = rdata_r;
    mlb_nxt   = mlb_r;
    miso_nxt  = miso_r;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ack_nxt   = 1'b0;
    ovf_nxt   = ovf_r;
    case (state_r)
      ST_IDLE: begin
        miso_nxt = 1'b0;
        if (ss_fall_s) begin
          state_nxt = ST_SHIFT;
          mlb_nxt   = mlb;
          cnt_nxt   = {CW{1'b0}};
          rx_nxt    = {DW{1'b0}};
          ovf_nxt   = 1'b0;
          if (ten) begin
            tx_load_s = tdata;
            ack_nxt   = 1'b1;
          end else begin
            tx_load_s = {DW{1'b0}};
          end
          // CPHA=0 has no leading shift edge, so bit 0 goes out at frame start.
          if (CPHA) begin
            tx_nxt = tx_load_s;
          end else begin
            miso_nxt = tx_head(tx_load_s, mlb);
            tx_nxt   = tx_advance(tx_load_s, mlb);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_s) begin
          miso_nxt = tx_head(tx_shift_r, mlb_r);
          tx_nxt   = tx_advance(tx_shift_r, mlb_r);
        end else begin
          tx_nxt = tx_shift_r;
        end
        if (sample_s && (cnt_r < CNT_MAX)) begin
          rx_nxt  = rx_insert(rx_shift_r, mosi_s, mlb_r);
          cnt_nxt = cnt_r + CNT_ONE;
        end else begin
          rx_nxt = rx_shift_r;
        end
        // The final sample wins over a simultaneous ss rise.
        if (sample_s && (cnt_r == CNT_LAST)) begin
          rdata_nxt = rx_insert(rx_shift_r, mosi_s, mlb_r);
          done_nxt  = 1'b1;
          miso_nxt  = 1'b0;
          state_nxt = ST_HOLD;
        end else if (ss_rise_s) begin
          err_nxt   = 1'b1;
          miso_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        miso_nxt = 1'b0;
        if (sample_s) begin
          ovf_nxt = 1'b1;
        end else begin
          ovf_nxt = ovf_r;
        end
        if (ss_rise_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      default: begin
        miso_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame state and registered outputs; miso is forced low whenever not enabled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      rx_shift_r <= {DW{1'b0}};
      tx_shift_r <= {DW{1'b0}};
      rdata_r    <= {DW{1'b0}};
      mlb_r      <= 1'b1;
      miso_r     <= 1'b0;
      miso_oe_r  <= 1'b0;
      done_r     <= 1'b0;
      rx_err_r   <= 1'b0;
      tx_ack_r   <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      rx_shift_r <= rx_nxt;
      tx_shift_r <= tx_nxt;
      rdata_r    <= rdata_nxt;
      mlb_r      <= mlb_nxt;
      miso_r     <= (armed_r & ~ss_s) ? miso_nxt : 1'b0;
      miso_oe_r  <= armed_r & ~ss_s;
      done_r     <= done_nxt;
      rx_err_r   <= err_nxt;
      tx_ack_r   <= ack_nxt;
      ovf_r      <= ovf_nxt;
    end
  end

  assign miso    = miso_r;
  assign miso_oe = miso_oe_r;
  assign tx_ack  = tx_ack_r;
  assign done    = done_r;
  assign rdata   = rdata_r;
  assign rx_err  = rx_err_r;
  assign ovf     = ovf_r;

endmodule
